// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory request at a time, extracts load data,
// and times out stalled requests. Define MEM_MISALIGN_CHK_EN to reject misaligned accesses.
module mem_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_reg_w,
    input  logic        ex_wb_sel,
    input  logic        ex_mem_r,
    input  logic        ex_mem_w,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_pc4,
    input  logic [31:0] ex_rs2_data,
    input  logic [4:0]  ex_rd_addr,
    output logic        stall_from_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        reg_w_from_MEM,
    output logic        wb_sel_from_MEM,
    output logic [31:0] rd_from_pc,
    output logic [31:0] rd_from_mem,
    output logic [4:0]  rd_addr_from_MEM,
    output logic        mem_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        op_store_q, op_store_d;
    logic [2:0]  op_funct3_q, op_funct3_d;
    logic [31:0] op_addr_q, op_addr_d;
    logic [31:0] op_wdata_q, op_wdata_d;
    logic [3:0]  op_be_q, op_be_d;
    logic        op_reg_w_q, op_reg_w_d;
    logic        op_wb_sel_q, op_wb_sel_d;
    logic [31:0] op_pc4_q, op_pc4_d;
    logic [4:0]  op_rd_q, op_rd_d;
    logic        reg_w_q, reg_w_d;
    logic        wb_sel_q, wb_sel_d;
    logic [31:0] rd_from_pc_q, rd_from_pc_d;
    logic [31:0] rd_from_mem_q, rd_from_mem_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic        mem_err_q, mem_err_d;

    logic        is_mem_op;
    logic        misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    assign is_mem_op = ex_mem_r | ex_mem_w;

`ifdef MEM_MISALIGN_CHK_EN
    assign misaligned = ((ex_funct3[1:0] == 2'b01) && ex_alu_out[0]) ||
                        ((ex_funct3[1:0] == 2'b10) && (ex_alu_out[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Store lanes are replicated so the selected byte enables always see the operand.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_rs2_data;
        case (ex_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << ex_alu_out[1:0];
                st_wdata = {4{ex_rs2_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {ex_alu_out[1], 1'b0};
                st_wdata = {2{ex_rs2_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op_addr_q[1:0])
            2'b00:   load_byte = dmem_rdata[7:0];
            2'b01:   load_byte = dmem_rdata[15:8];
            2'b10:   load_byte = dmem_rdata[23:16];
            default: load_byte = dmem_rdata[31:24];
        endcase
        load_half = op_addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_funct3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'd0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_store_d    = op_store_q;
        op_funct3_d   = op_funct3_q;
        op_addr_d     = op_addr_q;
        op_wdata_d    = op_wdata_q;
        op_be_d       = op_be_q;
        op_reg_w_d    = op_reg_w_q;
        op_wb_sel_d   = op_wb_sel_q;
        op_pc4_d      = op_pc4_q;
        op_rd_d       = op_rd_q;
        reg_w_d       = reg_w_q;
        wb_sel_d      = wb_sel_q;
        rd_from_pc_d  = rd_from_pc_q;
        rd_from_mem_d = rd_from_mem_q;
        rd_addr_d     = rd_addr_q;
        mem_err_d     = 1'b0;

        if (state_q == IDLE) begin
            if (ex_valid && !is_mem_op) begin
                reg_w_d       = ex_reg_w;
                wb_sel_d      = ex_wb_sel;
                rd_from_pc_d  = ex_pc4;
                rd_from_mem_d = ex_alu_out;
                rd_addr_d     = ex_rd_addr;
            end else begin
                reg_w_d       = 1'b0;
                wb_sel_d      = 1'b0;
                rd_from_pc_d  = 32'd0;
                rd_from_mem_d = 32'd0;
                rd_addr_d     = 5'd0;
                if (ex_valid && misaligned) begin
                    mem_err_d = 1'b1;
                end else if (ex_valid) begin
                    state_d     = REQ;
                    cnt_d       = 8'd0;
                    op_store_d  = ex_mem_w;
                    op_funct3_d = ex_funct3;
                    op_addr_d   = ex_alu_out;
                    op_wdata_d  = ex_mem_w ? st_wdata : 32'd0;
                    op_be_d     = ex_mem_w ? st_be : 4'b1111;
                    op_reg_w_d  = ex_reg_w;
                    op_wb_sel_d = ex_wb_sel;
                    op_pc4_d    = ex_pc4;
                    op_rd_d     = ex_rd_addr;
                end
            end
        end else if (dmem_ack) begin
            // Ack wins over a timeout landing on the same edge.
            state_d       = IDLE;
            cnt_d         = 8'd0;
            reg_w_d       = op_store_q ? 1'b0 : op_reg_w_q;
            wb_sel_d      = op_wb_sel_q;
            rd_from_pc_d  = op_pc4_q;
            rd_from_mem_d = op_store_q ? op_addr_q : load_data;
            rd_addr_d     = op_rd_q;
        end else if (cnt_q == LAST_WAIT) begin
            state_d       = IDLE;
            cnt_d         = 8'd0;
            mem_err_d     = 1'b1;
            reg_w_d       = 1'b0;
            wb_sel_d      = 1'b0;
            rd_from_pc_d  = 32'd0;
            rd_from_mem_d = 32'd0;
            rd_addr_d     = 5'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            op_store_q    <= 1'b0;
            op_funct3_q   <= 3'd0;
            op_addr_q     <= 32'd0;
            op_wdata_q    <= 32'd0;
            op_be_q       <= 4'd0;
            op_reg_w_q    <= 1'b0;
            op_wb_sel_q   <= 1'b0;
            op_pc4_q      <= 32'd0;
            op_rd_q       <= 5'd0;
            reg_w_q       <= 1'b0;
            wb_sel_q      <= 1'b0;
            rd_from_pc_q  <= 32'd0;
            rd_from_mem_q <= 32'd0;
            rd_addr_q     <= 5'd0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_store_q    <= op_store_d;
            op_funct3_q   <= op_funct3_d;
            op_addr_q     <= op_addr_d;
            op_wdata_q    <= op_wdata_d;
            op_be_q       <= op_be_d;
            op_reg_w_q    <= op_reg_w_d;
            op_wb_sel_q   <= op_wb_sel_d;
            op_pc4_q      <= op_pc4_d;
            op_rd_q       <= op_rd_d;
            reg_w_q       <= reg_w_d;
            wb_sel_q      <= wb_sel_d;
            rd_from_pc_q  <= rd_from_pc_d;
            rd_from_mem_q <= rd_from_mem_d;
            rd_addr_q     <= rd_addr_d;
            mem_err_q     <= mem_err_d;
        end
    end

    assign stall_from_MEM   = (state_q == REQ);
    assign dmem_req         = (state_q == REQ);
    assign dmem_we          = (state_q == REQ) && op_store_q;
    assign dmem_be          = (state_q == REQ) ? op_be_q : 4'd0;
    assign dmem_addr        = (state_q == REQ) ? {op_addr_q[31:2], 2'b00} : 32'd0;
    assign dmem_wdata       = (state_q == REQ) ? op_wdata_q : 32'd0;
    assign reg_w_from_MEM   = reg_w_q;
    assign wb_sel_from_MEM  = wb_sel_q;
    assign rd_from_pc       = rd_from_pc_q;
    assign rd_from_mem      = rd_from_mem_q;
    assign rd_addr_from_MEM = rd_addr_q;
    assign mem_err          = mem_err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a byte-addressed memory model.
module tb_mem_stage;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_reg_w, ex_wb_sel, ex_mem_r, ex_mem_w;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_out, ex_pc4, ex_rs2_data;
    logic [4:0]  ex_rd_addr;
    logic        stall_from_MEM, dmem_req, dmem_we, dmem_ack, mem_err;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        reg_w_from_MEM, wb_sel_from_MEM;
    logic [31:0] rd_from_pc, rd_from_mem;
    logic [4:0]  rd_addr_from_MEM;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [64];

    mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_reg_w(ex_reg_w), .ex_wb_sel(ex_wb_sel),
        .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w), .ex_funct3(ex_funct3),
        .ex_alu_out(ex_alu_out), .ex_pc4(ex_pc4), .ex_rs2_data(ex_rs2_data),
        .ex_rd_addr(ex_rd_addr), .stall_from_MEM(stall_from_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .reg_w_from_MEM(reg_w_from_MEM),
        .wb_sel_from_MEM(wb_sel_from_MEM), .rd_from_pc(rd_from_pc),
        .rd_from_mem(rd_from_mem), .rd_addr_from_MEM(rd_addr_from_MEM),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic rw, input logic ws,
                                 input logic mr, input logic mw, input logic [2:0] f3,
                                 input logic [31:0] alu, input logic [31:0] pc4,
                                 input logic [31:0] rs2, input logic [4:0] rd);
        ex_valid = valid; ex_reg_w = rw; ex_wb_sel = ws; ex_mem_r = mr; ex_mem_w = mw;
        ex_funct3 = f3; ex_alu_out = alu; ex_pc4 = pc4; ex_rs2_data = rs2; ex_rd_addr = rd;
    endtask

    // Reference load: gather n bytes from the naturally aligned slot and extend.
    function automatic logic [31:0] loadValue(input logic [2:0] f3, input logic [31:0] addr);
        int n, start, base;
        logic [31:0] v;
        n = 1 << f3[1:0];
        start = int'(addr[1:0]) - (int'(addr[1:0]) % n);
        base = int'(addr[5:2]) * 4;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mem[base + start + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic aluOp(input logic valid, input logic rw, input logic ws,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [4:0] rd);
        applyStimulus(valid, rw, ws, 1'b0, 1'b0, 3'($urandom_range(0, 7)), alu, pc4, $urandom, rd);
        dmem_ack = 1'($urandom_range(0, 1));
        step();
        dmem_ack = 1'b0;
        checkOutput("alu_stall", 32'(stall_from_MEM), 32'd0);
        checkOutput("alu_req", 32'(dmem_req), 32'd0);
        if (valid) begin
            checkOutput("alu_reg_w", 32'(reg_w_from_MEM), 32'(rw));
            checkOutput("alu_wb_sel", 32'(wb_sel_from_MEM), 32'(ws));
            checkOutput("alu_rd_mem", rd_from_mem, alu);
            checkOutput("alu_rd_pc", rd_from_pc, pc4);
            checkOutput("alu_rd_addr", 32'(rd_addr_from_MEM), 32'(rd));
        end else begin
            checkOutput("bubble_reg_w", 32'(reg_w_from_MEM), 32'd0);
        end
    endtask

    task automatic doMemOp(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rs2, input logic [4:0] rd, input logic rw,
                           input logic ws, input logic [31:0] pc4, input int ackAt);
        int n, start, base;
        logic [3:0] be;
        logic [31:0] wd, word, expLoad;
        logic mis;
        bit acked;
        n = 1 << f3[1:0];
        start = int'(addr[1:0]) - (int'(addr[1:0]) % n);
        base = int'(addr[5:2]) * 4;
        be = st ? 4'(((1 << n) - 1) << start) : 4'hF;
        wd = 32'd0;
        for (int i = 0; i < 4; i++) wd[8 * i +: 8] = rs2[8 * (i % n) +: 8];
        word = {mem[base + 3], mem[base + 2], mem[base + 1], mem[base]};
        expLoad = loadValue(f3, addr);
        mis = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
        mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`endif
        applyStimulus(1'b1, rw, ws, ~st, st, f3, addr, pc4, rs2, rd);
        dmem_ack = 1'($urandom_range(0, 1));
        step();
        if (mis) begin
            dmem_ack = 1'b0;
            checkOutput("mis_req", 32'(dmem_req), 32'd0);
            checkOutput("mis_err", 32'(mem_err), 32'd1);
            checkOutput("mis_reg_w", 32'(reg_w_from_MEM), 32'd0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
            step();
            checkOutput("mis_err_pulse", 32'(mem_err), 32'd0);
            return;
        end
        checkOutput("req_bubble", 32'(reg_w_from_MEM), 32'd0);
        checkOutput("req_we", 32'(dmem_we), 32'(st));
        checkOutput("req_be", 32'(dmem_be), 32'(be));
        if (st) checkOutput("req_wdata", dmem_wdata, wd);
        acked = 1'b0;
        for (int k = 1; k <= MAX_WAIT; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0,
                          3'd2, $urandom, $urandom, $urandom, 5'($urandom));
            dmem_ack = (k == ackAt);
            dmem_rdata = (k == ackAt) ? word : $urandom;
            checkOutput("req_stall", 32'(stall_from_MEM), 32'd1);
            checkOutput("req_req", 32'(dmem_req), 32'd1);
            checkOutput("req_addr", dmem_addr, {addr[31:2], 2'b00});
            checkOutput("req_be_hold", 32'(dmem_be), 32'(be));
            step();
            if (k == ackAt) begin
                acked = 1'b1;
                break;
            end
        end
        dmem_ack = 1'b0;
        checkOutput("done_stall", 32'(stall_from_MEM), 32'd0);
        checkOutput("done_req", 32'(dmem_req), 32'd0);
        if (acked) begin
            checkOutput("done_err", 32'(mem_err), 32'd0);
            checkOutput("done_reg_w", 32'(reg_w_from_MEM), st ? 32'd0 : 32'(rw));
            checkOutput("done_rd_addr", 32'(rd_addr_from_MEM), 32'(rd));
            checkOutput("done_rd_pc", rd_from_pc, pc4);
            checkOutput("done_wb_sel", 32'(wb_sel_from_MEM), 32'(ws));
            if (!st) checkOutput("load_data", rd_from_mem, expLoad);
            if (st) for (int i = 0; i < 4; i++) if (be[i]) mem[base + i] = wd[8 * i +: 8];
        end else begin
            checkOutput("tmo_err", 32'(mem_err), 32'd1);
            checkOutput("tmo_reg_w", 32'(reg_w_from_MEM), 32'd0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
            step();
            checkOutput("tmo_err_pulse", 32'(mem_err), 32'd0);
        end
    endtask

    initial begin
        logic [2:0] loadF3 [5];
        logic st;
        logic [2:0] f3;
        loadF3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        rst = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        #3;
        checkOutput("rst_req", 32'(dmem_req), 32'd0);
        checkOutput("rst_stall", 32'(stall_from_MEM), 32'd0);
        checkOutput("rst_reg_w", 32'(reg_w_from_MEM), 32'd0);
        checkOutput("rst_err", 32'(mem_err), 32'd0);
        @(negedge clk) rst = 1'b1;

        aluOp(1'b1, 1'b1, 1'b0, 32'h0000_1234, 32'h0000_0044, 5'd5);
        mem[3] = 8'h80;
        doMemOp(1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd7, 1'b1, 1'b1, 32'h10, 3);
        checkOutput("lb_const", rd_from_mem, 32'hFFFF_FF80);
        doMemOp(1'b0, 3'b100, 32'h0000_0103, 32'd0, 5'd7, 1'b1, 1'b1, 32'h14, 3);
        checkOutput("lbu_const", rd_from_mem, 32'h0000_0080);
        doMemOp(1'b1, 3'b001, 32'h0000_0202, 32'hABCD_1234, 5'd3, 1'b1, 1'b0, 32'h18, 2);
        doMemOp(1'b0, 3'b010, 32'h0000_0040, 32'd0, 5'd9, 1'b1, 1'b1, 32'h1C, MAX_WAIT + 1);
        doMemOp(1'b0, 3'b010, 32'h0000_0044, 32'd0, 5'd9, 1'b1, 1'b1, 32'h20, MAX_WAIT);
        doMemOp(1'b0, 3'b010, 32'h0000_0101, 32'd0, 5'd4, 1'b1, 1'b1, 32'h24, 2);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0048, 32'h28, 32'd0, 5'd6);
        step();
        checkOutput("rr_req1", 32'(dmem_req), 32'd1);
        step();
        #2 rst = 1'b0;
        #1;
        checkOutput("rr_req", 32'(dmem_req), 32'd0);
        checkOutput("rr_stall", 32'(stall_from_MEM), 32'd0);
        checkOutput("rr_err", 32'(mem_err), 32'd0);
        checkOutput("rr_be", 32'(dmem_be), 32'd0);
        @(negedge clk) rst = 1'b1;
        aluOp(1'b1, 1'b1, 1'b1, 32'hCAFE_0001, 32'h0000_002C, 5'd12);

        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 9) < 3) begin
                aluOp(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom));
            end else begin
                st = 1'($urandom_range(0, 1));
                f3 = st ? 3'($urandom_range(0, 2)) : loadF3[$urandom_range(0, 4)];
                doMemOp(st, f3, $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom, $urandom_range(1, MAX_WAIT + 1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
